fwd_fft_mul_arbiter: RTL and testbench
======================================

# fwd_fft_mul_arbiter

Round-robin scheduler that shares one pipelined 24x16 unsigned multiplier (fwd_fft_mul_mul_24ns_16ns_32_4_1 instance, outside this block) between NREQ requesters in the forward-FFT datapath, such as twiddle scaling and window gain. The block accepts one operand pair per cycle from the granted requester and drives the multiplier's shared ce. It tracks the requester ID of every in-flight product and routes each result back to its owner over a valid/ready port. Back-pressure on any returning result freezes the whole multiplier pipeline through ce, so no product is ever dropped.

## Interface
- NREQ, 4, number of requesters (2..8)
- MUL_LAT, 3, ce-qualified clock edges from operand presentation on mul_din0/1 to product on mul_dout; must match the attached multiplier
- IDW, clog2(NREQ), requester-ID width (derived, not overridable)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*24  packed unsigned operand A; requester i at bits [24i+23:24i]
- req_b  in  NREQ*16  packed unsigned operand B; requester i at bits [16i+15:16i]
- res_valid  out  NREQ  one-hot result valid for the owning requester
- res_ready  in  NREQ  per-requester result accept
- res_data  out  32  shared result bus; low 32 bits of a*b
- mul_ce  out  1  multiplier clock enable
- mul_din0  out  24  multiplier operand A
- mul_din1  out  16  multiplier operand B
- mul_dout  in  32  multiplier product
- busy  out  1  any product in flight

## Operation
- Tracking pipe: MUL_LAT stages of {vld, id[IDW-1:0]}. The pipe shifts only when mul_ce=1. Stage 0 loads {issue, grant_id}. The last stage corresponds to mul_dout.
- Stall: stall = last.vld & ~res_ready[last.id]. mul_ce = ~stall. This is combinational.
- Results: res_valid[i] = last.vld & (last.id==i). res_data = mul_dout when last.vld, else 0.
- Arbitration: round-robin pointer ptr. Grant goes to the first i with req_valid[i], searching ptr, ptr+1, ... modulo NREQ.
- Issue: issue = mul_ce & |req_valid. req_ready[grant_id] = issue; all other req_ready bits are 0.
- On issue, ptr <= grant_id+1 (mod NREQ). Otherwise ptr holds.
- Operand muxing: mul_din0/mul_din1 = operands of the granted requester when issue=1, else 0.
- Stage 0 gets vld=0 on non-issue shift cycles (bubbles).
- When mul_ce=0, no issue occurs and req_ready is all 0. The pipe, ptr and multiplier all hold.
- busy = OR of all stage vld bits.
- A result is consumed on the cycle res_valid & res_ready. The same edge shifts the pipe, so a new result can present every cycle.
- Arithmetic: both operands are unsigned. The product is 40 bits; the multiplier returns bits [31:0]. The arbiter does not check for truncation.

## Timing
- Reset (reset=0 at a rising edge):
  - Control: ptr=0, all stage vld=0, mul_ce=1.
  - Request side: req_ready=0, res_valid=0, res_data=0, busy=0.
  - Multiplier side: mul_din0=0 and mul_din1=0 while reset is held.
  - Reset in mid-operation discards all in-flight products. The multiplier's stale contents are ignored because the vld bits are cleared.
- Latency: an operand accepted at edge T produces res_valid at edge T+MUL_LAT, assuming no stall. A stall of k cycles extends this to T+MUL_LAT+k.
- Throughput: one issue per cycle while no stall is active.
- Handshake: req_ready depends combinationally on req_valid and res_ready. Requesters must not make req_valid depend on req_ready.
- A requester may hold req_valid high; it is re-granted only after every other valid requester has been served once.
- Simultaneous events: an issue and a result consumption in the same cycle are both legal. A stall in a cycle blocks that cycle's issue.
- Bubbles never stall; only a valid last stage can stall.

## Test plan
- Single requester, back-to-back:
  - Stimulus: requester 0 issues (a,b) = (0x000003,0x0005), then (0xFFFFFF,0xFFFF), each once with res_ready=all 1.
  - Required response: res_data 15 and then 0xFEFF0001 on res_valid[0]; the first arrives 3 cycles after acceptance and the second one cycle later.
- Round-robin fairness:
  - Stimulus: all 4 req_valid held high for 8 cycles with a=i+1 and b=2 for requester i.
  - Required response: grant order 0,1,2,3,0,1,2,3; results 2,4,6,8 repeated, each with the matching one-hot res_valid.
- Back-pressure:
  - Stimulus: requesters 1 and 2 issue alternately; res_ready[2]=0 for 5 cycles once a requester-2 result reaches the output.
  - Required response: mul_ce=0 for exactly those 5 cycles; req_ready=0 throughout; no result lost or duplicated; order preserved once res_ready[2]=1.
- Bubble handling:
  - Stimulus: requester 3 issues on cycles 0 and 2 only.
  - Required response: res_valid[3] on cycles 3 and 5; res_valid=0 on cycle 4 with no stall; busy falls after cycle 5.
- Reset in mid-flight:
  - Stimulus: 3 products in flight, then reset=0 for 1 cycle.
  - Required response: res_valid never asserts for those products; busy=0 and ptr=0 after reset; a fresh request (7,6) returns 42.
- Pointer wrap:
  - Stimulus: NREQ=4, only requesters 3 and 0 valid.
  - Required response: grants alternate 3,0,3,0.

Source files
------------

// File: rtl/fwd_fft_mul_arbiter.sv
// fwd_fft_mul_arbiter
// Round-robin scheduler sharing one pipelined 24x16 unsigned multiplier among
// NREQ requesters. Tracks the owner of every in-flight product and returns
// each result over a valid/ready port. Back-pressure on the returning result
// freezes the whole multiplier pipeline via mul_ce_o, so no product is lost.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_ni     synchronous active-low reset
//   req_valid_i  per-requester operand valid
//   req_ready_o  per-requester accept (one-hot or zero)
//   req_a_i      packed operand A, requester i at [24i+23:24i]
//   req_b_i      packed operand B, requester i at [16i+15:16i]
//   res_valid_o  one-hot result valid for the owning requester
//   res_ready_i  per-requester result accept
//   res_data_o   shared result bus (low 32 bits of a*b)
//   mul_ce_o     multiplier clock enable
//   mul_din0_o   multiplier operand A
//   mul_din1_o   multiplier operand B
//   mul_dout_i   multiplier product
//   busy_o       any product in flight
module fwd_fft_mul_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned MUL_LAT = 3
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic [NREQ-1:0]      req_valid_i,
   output logic [NREQ-1:0]      req_ready_o,
   input  logic [NREQ*24-1:0]   req_a_i,
   input  logic [NREQ*16-1:0]   req_b_i,
   output logic [NREQ-1:0]      res_valid_o,
   input  logic [NREQ-1:0]      res_ready_i,
   output logic [31:0]          res_data_o,
   output logic                 mul_ce_o,
   output logic [23:0]          mul_din0_o,
   output logic [15:0]          mul_din1_o,
   input  logic [31:0]          mul_dout_i,
   output logic                 busy_o
);

   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Tracking pipe mirrors the multiplier stages; the last stage lines up with mul_dout_i
   logic [MUL_LAT-1:0]           vld_q, vld_d;
   logic [MUL_LAT-1:0][IDW-1:0]  id_q, id_d;
   logic [IDW-1:0]               ptr_q, ptr_d;

   logic            grant_found;
   logic [IDW-1:0]  grant_id;
   logic            last_vld;
   logic [IDW-1:0]  last_id;
   logic            stall;
   logic            issue;

   // Round-robin search starting at ptr_q
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!grant_found && req_valid_i[(32'(ptr_q) + k) % NREQ]) begin
            grant_found = 1'b1;
            grant_id    = IDW'((32'(ptr_q) + k) % NREQ);
         end
      end
   end

   // Gating with reset_ni hides stale in-flight products during the reset cycle
   assign last_vld = vld_q[MUL_LAT-1] & reset_ni;
   assign last_id  = id_q[MUL_LAT-1];
   assign stall    = last_vld & ~res_ready_i[last_id];
   assign mul_ce_o = ~stall;
   assign issue    = mul_ce_o & grant_found & reset_ni;

   always_comb begin
      req_ready_o = '0;
      mul_din0_o  = '0;
      mul_din1_o  = '0;
      if (issue) begin
         req_ready_o = NREQ'(1) << grant_id;
         mul_din0_o  = req_a_i[32'(grant_id) * 24 +: 24];
         mul_din1_o  = req_b_i[32'(grant_id) * 16 +: 16];
      end
   end

   always_comb begin
      res_valid_o = '0;
      res_data_o  = '0;
      if (last_vld) begin
         res_valid_o = NREQ'(1) << last_id;
         res_data_o  = mul_dout_i;
      end
   end

   assign busy_o = |vld_q;

   always_comb begin
      vld_d = vld_q;
      id_d  = id_q;
      ptr_d = ptr_q;
      if (mul_ce_o) begin
         for (int unsigned s = 1; s < MUL_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            id_d[s]  = id_q[s-1];
         end
         // Non-issue shift cycles insert a bubble
         vld_d[0] = issue;
         id_d[0]  = grant_id;
      end
      if (issue) begin
         ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         vld_q <= '0;
         id_q  <= '0;
         ptr_q <= '0;
      end else begin
         vld_q <= vld_d;
         id_q  <= id_d;
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: tb/tb_fwd_fft_mul_arbiter.sv
// Bench for fwd_fft_mul_arbiter: directed tests, a transaction-level
// scoreboard checked every cycle, and literal expectations per scenario.
module tb_fwd_fft_mul_arbiter;

   localparam int NREQ    = 4;
   localparam int MUL_LAT = 3;

   logic                clk;
   logic                reset_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*24-1:0]  req_a;
   logic [NREQ*16-1:0]  req_b;
   logic [NREQ-1:0]     res_valid;
   logic [NREQ-1:0]     res_ready;
   logic [31:0]         res_data;
   logic                mul_ce;
   logic [23:0]         mul_din0;
   logic [15:0]         mul_din1;
   logic [31:0]         mul_dout;
   logic                busy;

   fwd_fft_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
      .clk_i       (clk),
      .reset_ni    (reset_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .res_data_o  (res_data),
      .mul_ce_o    (mul_ce),
      .mul_din0_o  (mul_din0),
      .mul_din1_o  (mul_din1),
      .mul_dout_i  (mul_dout),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Attached multiplier: MUL_LAT ce-qualified stages, low 32 bits of the product
   logic [31:0] mp [MUL_LAT];
   initial for (int i = 0; i < MUL_LAT; i++) mp[i] = '0;
   always @(posedge clk) begin
      if (mul_ce) begin
         mp[0] <= 32'(40'(mul_din0) * 40'(mul_din1));
         for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
      end
   end
   assign mul_dout = mp[MUL_LAT-1];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit started = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: in-flight products tagged with the ce-count at issue
   typedef struct {int id; logic [31:0] prod; int k;} infl_t;
   infl_t q[$];
   int n = 0;
   int m_ptr = 0;

   typedef struct {int cyc; int id; logic [31:0] data;} ev_t;
   ev_t grants[$];
   ev_t results[$];
   int stall_cnt = 0;
   int last_busy = -1;

   function automatic int onehot_id(input logic [NREQ-1:0] v);
      int r = -1;
      for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   always @(negedge clk) begin
      if (started) begin
         if (!reset_n) begin
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_res_valid", 64'(res_valid), 64'(0));
            chk("rst_res_data", 64'(res_data), 64'(0));
            chk("rst_mul_ce", 64'(mul_ce), 64'(1));
            chk("rst_din0", 64'(mul_din0), 64'(0));
            chk("rst_din1", 64'(mul_din1), 64'(0));
            q.delete();
            n = 0;
            m_ptr = 0;
         end else begin
            int g;
            bit found, present, e_ce, e_issue;
            logic [NREQ-1:0] e_rdy, e_rv;
            logic [23:0] e_a;
            logic [15:0] e_b;
            logic [31:0] e_rd;
            g = 0;
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
               if (!found && req_valid[(m_ptr + k) % NREQ]) begin
                  found = 1;
                  g = (m_ptr + k) % NREQ;
               end
            end
            present = (q.size() > 0) && (q[0].k + MUL_LAT == n);
            e_ce = !(present && !res_ready[q[0].id]);
            e_issue = e_ce && found;
            e_rdy = e_issue ? NREQ'(1) << g : '0;
            e_a = e_issue ? req_a[g*24 +: 24] : '0;
            e_b = e_issue ? req_b[g*16 +: 16] : '0;
            e_rv = present ? NREQ'(1) << q[0].id : '0;
            e_rd = present ? q[0].prod : '0;
            chk("req_ready", 64'(req_ready), 64'(e_rdy));
            chk("mul_ce", 64'(mul_ce), 64'(e_ce));
            chk("mul_din0", 64'(mul_din0), 64'(e_a));
            chk("mul_din1", 64'(mul_din1), 64'(e_b));
            chk("res_valid", 64'(res_valid), 64'(e_rv));
            chk("res_data", 64'(res_data), 64'(e_rd));
            chk("busy", 64'(busy), 64'(q.size() > 0));
            // Observation logs used by the literal checks
            if (req_ready != 0) grants.push_back('{cyc, onehot_id(req_ready), 32'(0)});
            if ((res_valid & res_ready) != 0)
               results.push_back('{cyc, onehot_id(res_valid), res_data});
            if (!mul_ce) stall_cnt++;
            if (busy) last_busy = cyc;
            // Advance the model
            if (present && e_ce) void'(q.pop_front());
            if (e_issue) begin
               q.push_back('{g, 32'(40'(e_a) * 40'(e_b)), n});
               m_ptr = (g + 1) % NREQ;
            end
            if (e_ce) n++;
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [23:0] a, input logic [15:0] b);
      req_a[i*24 +: 24] = a;
      req_b[i*16 +: 16] = b;
   endtask

   task automatic clear_logs();
      grants.delete();
      results.delete();
      stall_cnt = 0;
      last_busy = -1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      res_ready = '1;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      clear_logs();
   endtask

   function automatic int gid(input int i);
      return (i < grants.size()) ? grants[i].id : -1;
   endfunction
   function automatic int rid(input int i);
      return (i < results.size()) ? results[i].id : -1;
   endfunction
   function automatic int rcyc(input int i);
      return (i < results.size()) ? results[i].cyc : -1;
   endfunction
   function automatic logic [31:0] rdat(input int i);
      return (i < results.size()) ? results[i].data : 32'hDEADBEEF;
   endfunction

   initial begin
      int base;
      int stall_left;
      bit done;
      reset_n = 1'b0;
      req_valid = '0;
      res_ready = '1;
      req_a = '0;
      req_b = '0;
      tick();
      started = 1;

      // Single requester, back-to-back
      do_reset();
      set_op(0, 24'h000003, 16'h0005);
      req_valid = 4'b0001;
      tick();
      set_op(0, 24'hFFFFFF, 16'hFFFF);
      tick();
      req_valid = '0;
      repeat (8) tick();
      chk("t1_grants", 64'(grants.size()), 64'(2));
      chk("t1_results", 64'(results.size()), 64'(2));
      chk("t1_data0", 64'(rdat(0)), 64'(15));
      chk("t1_data1", 64'(rdat(1)), 64'(32'hFEFF0001));
      chk("t1_id0", 64'(rid(0)), 64'(0));
      chk("t1_lat", 64'(rcyc(0) - (grants.size() > 0 ? grants[0].cyc : 0)), 64'(3));
      chk("t1_gap", 64'(rcyc(1) - rcyc(0)), 64'(1));

      // Round-robin fairness
      do_reset();
      for (int i = 0; i < NREQ; i++) set_op(i, 24'(i + 1), 16'd2);
      req_valid = 4'b1111;
      repeat (8) tick();
      req_valid = '0;
      repeat (8) tick();
      chk("t2_grants", 64'(grants.size()), 64'(8));
      chk("t2_results", 64'(results.size()), 64'(8));
      for (int i = 0; i < 8; i++) begin
         chk("t2_gid", 64'(gid(i)), 64'(i % 4));
         chk("t2_rid", 64'(rid(i)), 64'(i % 4));
         chk("t2_data", 64'(rdat(i)), 64'(2 * (i % 4 + 1)));
      end

      // Back-pressure on requester 2
      do_reset();
      set_op(1, 24'd10, 16'd3);
      set_op(2, 24'd20, 16'd7);
      req_valid = 4'b0110;
      stall_left = 0;
      done = 0;
      for (int c = 0; c < 15; c++) begin
         if (!done && res_valid[2]) begin
            res_ready[2] = 1'b0;
            stall_left = 5;
            done = 1;
         end
         tick();
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) res_ready = '1;
         end
      end
      req_valid = '0;
      repeat (10) tick();
      chk("t3_stall_cycles", 64'(stall_cnt), 64'(5));
      chk("t3_grants", 64'(grants.size()), 64'(10));
      chk("t3_results", 64'(results.size()), 64'(10));
      for (int i = 0; i < 10; i++) begin
         chk("t3_gid", 64'(gid(i)), 64'((i % 2 == 1) ? 2 : 1));
         chk("t3_rid", 64'(rid(i)), 64'((i % 2 == 1) ? 2 : 1));
         chk("t3_data", 64'(rdat(i)), 64'((i % 2 == 1) ? 140 : 30));
      end

      // Bubble handling
      do_reset();
      set_op(3, 24'd9, 16'd9);
      base = cyc;
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      tick();
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      repeat (8) tick();
      chk("t4_results", 64'(results.size()), 64'(2));
      chk("t4_cyc0", 64'(rcyc(0)), 64'(base + 3));
      chk("t4_cyc1", 64'(rcyc(1)), 64'(base + 5));
      chk("t4_data", 64'(rdat(1)), 64'(81));
      chk("t4_stalls", 64'(stall_cnt), 64'(0));
      chk("t4_busy_end", 64'(last_busy), 64'(base + 5));

      // Reset in mid-flight
      do_reset();
      set_op(0, 24'd1, 16'd1);
      set_op(1, 24'd2, 16'd2);
      set_op(2, 24'd3, 16'd3);
      req_valid = 4'b0111;
      repeat (3) tick();
      req_valid = '0;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("t5_inflight", 64'(grants.size()), 64'(3));
      set_op(1, 24'd7, 16'd6);
      set_op(3, 24'd1, 16'd1);
      req_valid = 4'b1010;
      tick();
      req_valid = '0;
      repeat (6) tick();
      chk("t5_grants", 64'(grants.size()), 64'(4));
      chk("t5_fresh_gid", 64'(gid(3)), 64'(1));
      chk("t5_results", 64'(results.size()), 64'(1));
      chk("t5_data", 64'(rdat(0)), 64'(42));
      chk("t5_rid", 64'(rid(0)), 64'(1));

      // Pointer wrap (pointer is 2 after the previous grant)
      clear_logs();
      set_op(3, 24'd5, 16'd5);
      set_op(0, 24'd4, 16'd4);
      req_valid = 4'b1001;
      repeat (4) tick();
      req_valid = '0;
      repeat (8) tick();
      chk("t6_grants", 64'(grants.size()), 64'(4));
      for (int i = 0; i < 4; i++) begin
         chk("t6_gid", 64'(gid(i)), 64'((i % 2 == 0) ? 3 : 0));
         chk("t6_data", 64'(rdat(i)), 64'((i % 2 == 0) ? 25 : 16));
      end

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
